state_pacc_basemul_pair: RTL and testbench

STATE_PACC_BASEMUL_PAIR -- requirements
Module: state_pacc_basemul_pair

---
 rtl/state_pacc_basemul_pair.sv | 161 ++++++++++++++++
 tb/tb_state_pacc_basemul_pair.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/state_pacc_basemul_pair.sv
// state_pacc_basemul_pair
// Kyber base-case multiply of two degree-1 polynomials modulo (X^2 - zeta):
//   r0 = fqmul(fqmul(a1,b1),zeta) + fqmul(a0,b0)
//   r1 = fqmul(a0,b1) + fqmul(a1,b0)
// A single Montgomery multiplier (fqmul) is time-shared over five products.
// Each product takes three states (MUL_P, MUL_U, MUL_R). One SUM state then
// publishes the result. Done is registered, so it is seen on the 17th edge
// after the capture edge.
// The final additions wrap at 16 bits and are not reduced.
//
// Ports
//   clk                      : clock, rising edge
//   reset                    : synchronous active-high reset
//   enable                   : start request, sampled only in IDLE
//   iCoeffs_a0/a1, b0/b1     : signed input coefficients
//   iZeta                    : signed twiddle factor (Montgomery form)
//   busy                     : operation in flight
//   Basemul_done             : one-cycle completion pulse
//   oCoeffs_r0/r1            : signed result, held until the next SUM
module state_pacc_basemul_pair #(
  parameter int KYBER_Q   = 3329,
  parameter int MONT_QINV = 62209,
  parameter int COEFF_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [COEFF_W-1:0] iCoeffs_a0,
  input  logic [COEFF_W-1:0] iCoeffs_a1,
  input  logic [COEFF_W-1:0] iCoeffs_b0,
  input  logic [COEFF_W-1:0] iCoeffs_b1,
  input  logic [COEFF_W-1:0] iZeta,
  output logic               busy,
  output logic               Basemul_done,
  output logic [COEFF_W-1:0] oCoeffs_r0,
  output logic [COEFF_W-1:0] oCoeffs_r1
);

  localparam int PW = 2 * COEFF_W;
  localparam logic [COEFF_W-1:0] QINV_L = MONT_QINV[COEFF_W-1:0];
  localparam logic signed [PW-1:0] KQ = PW'(KYBER_Q);

  typedef enum logic [2:0] {IDLE, MUL_P, MUL_U, MUL_R, SUM} state_t;

  state_t state_q, state_d;
  logic [2:0] op_q, op_d;

  logic signed [COEFF_W-1:0] a0_q, a1_q, b0_q, b1_q, zeta_q;
  logic signed [COEFF_W-1:0] p0_q, acc0_q, acc1_q;
  logic signed [PW-1:0]      t_q;
  logic signed [COEFF_W-1:0] u_q;
  logic signed [COEFF_W-1:0] opx, opy, res;
  logic                      done_q;
  logic [COEFF_W-1:0]        r0_q, r1_q;

  function automatic logic signed [PW-1:0] sext(input logic signed [COEFF_W-1:0] v);
    return {{COEFF_W{v[COEFF_W-1]}}, v};
  endfunction

  // Only the low half of t*QINV is needed, and that depends only on the
  // low half of t. So a COEFF_W-wide multiply is enough.
  function automatic logic signed [COEFF_W-1:0] mont_u(input logic signed [PW-1:0] t);
    logic [COEFF_W-1:0] lo;
    lo = t[COEFF_W-1:0] * QINV_L;
    return lo;
  endfunction

  // (t - u*q) has a zero low half, so the arithmetic shift is exact.
  function automatic logic signed [COEFF_W-1:0] mont_r(input logic signed [PW-1:0] t,
                                                       input logic signed [COEFF_W-1:0] u);
    logic signed [PW-1:0] diff;
    diff = t - sext(u) * KQ;
    return diff[PW-1:COEFF_W];
  endfunction

  // Operand schedule. op1 takes the reduced op0 product as its x operand.
  always_comb begin
    opx = a1_q;
    opy = b1_q;
    case (op_q)
      3'd1: begin opx = p0_q; opy = zeta_q; end
      3'd2: begin opx = a0_q; opy = b0_q;   end
      3'd3: begin opx = a0_q; opy = b1_q;   end
      3'd4: begin opx = a1_q; opy = b0_q;   end
      default: ;
    endcase
  end

  assign res = mont_r(t_q, u_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      IDLE:  if (enable) begin state_d = MUL_P; op_d = 3'd0; end
      MUL_P: state_d = MUL_U;
      MUL_U: state_d = MUL_R;
      MUL_R: begin
        if (op_q == 3'd4) state_d = SUM;
        else begin
          state_d = MUL_P;
          op_d    = op_q + 3'd1;
        end
      end
      SUM:   begin state_d = IDLE; op_d = 3'd0; end
      default: begin state_d = IDLE; op_d = 3'd0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a0_q <= '0; a1_q <= '0; b0_q <= '0; b1_q <= '0; zeta_q <= '0;
      t_q <= '0; u_q <= '0; p0_q <= '0; acc0_q <= '0; acc1_q <= '0;
      r0_q <= '0; r1_q <= '0; done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (enable) begin
          a0_q   <= iCoeffs_a0;
          a1_q   <= iCoeffs_a1;
          b0_q   <= iCoeffs_b0;
          b1_q   <= iCoeffs_b1;
          zeta_q <= iZeta;
        end
        MUL_P: t_q <= sext(opx) * sext(opy);
        MUL_U: u_q <= mont_u(t_q);
        MUL_R: begin
          case (op_q)
            3'd0:    p0_q   <= res;
            3'd1:    acc0_q <= res;
            3'd2:    acc0_q <= acc0_q + res;
            3'd3:    acc1_q <= res;
            default: acc1_q <= acc1_q + res;
          endcase
        end
        SUM: begin
          r0_q   <= acc0_q;
          r1_q   <= acc1_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign Basemul_done = done_q;
  assign oCoeffs_r0   = r0_q;
  assign oCoeffs_r1   = r1_q;

endmodule

// File: tb/tb_state_pacc_basemul_pair.sv
// Testbench for state_pacc_basemul_pair. Each result is compared with a
// reference Kyber fqmul/basemul model written with plain integer arithmetic.
// Latency is the number of rising edges from the capture edge to the edge at
// which a synchronous consumer first samples Basemul_done high.
module tb_state_pacc_basemul_pair;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [15:0] a0, a1, b0, b1, zeta;
  logic        busy, done;
  logic [15:0] r0, r1;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  state_pacc_basemul_pair dut (
    .clk(clk), .reset(reset), .enable(enable),
    .iCoeffs_a0(a0), .iCoeffs_a1(a1), .iCoeffs_b0(b0), .iCoeffs_b1(b1),
    .iZeta(zeta), .busy(busy), .Basemul_done(done),
    .oCoeffs_r0(r0), .oCoeffs_r1(r1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Montgomery multiply as in the Kyber C reference:
  // the result is (x*y - u*q) / 2^16, where u = (x*y*qinv) mod 2^16, signed.
  function automatic logic [15:0] fqmul_ref(input logic [15:0] x, input logic [15:0] y);
    longint t, u, r;
    t = longint'($signed(x)) * longint'($signed(y));
    u = (t * -3327) & 64'hFFFF;
    if (u >= 32768) u = u - 65536;
    r = (t - u * 3329) / 65536;
    return r[15:0];
  endfunction

  function automatic logic [15:0] r0_ref(input logic [15:0] xa0, xa1, xb0, xb1, xz);
    return fqmul_ref(fqmul_ref(xa1, xb1), xz) + fqmul_ref(xa0, xb0);
  endfunction

  function automatic logic [15:0] r1_ref(input logic [15:0] xa0, xa1, xb0, xb1, xz);
    return fqmul_ref(xa0, xb1) + fqmul_ref(xa1, xb0);
  endfunction

  task automatic run_op(input logic [15:0] xa0, xa1, xb0, xb1, xz,
                        input bit toggle, input bit chk_lat,
                        output logic [15:0] g0, output logic [15:0] g1);
    int  cap;
    bit  found;
    @(negedge clk);
    a0 = xa0; a1 = xa1; b0 = xb0; b1 = xb1; zeta = xz;
    enable = 1'b1;
    @(negedge clk);
    cap = cyc;
    enable = 1'b0;
    if (chk_lat) chk("busy_after_capture", 32'(busy), 32'd1);
    found = 1'b0;
    g0 = 'x;
    g1 = 'x;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (done) begin found = 1'b1; break; end
      if (toggle && busy) begin
        a0 = 16'($urandom); a1 = 16'($urandom); b0 = 16'($urandom);
        b1 = 16'($urandom); zeta = 16'($urandom); enable = 1'($urandom);
      end else enable = 1'b0;
    end
    enable = 1'b0;
    if (!found) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      g0 = r0;
      g1 = r1;
      if (chk_lat) begin
        chk("latency", 32'(cyc - cap + 1), 32'd17);
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
      end
    end
  endtask

  logic [15:0] g0, g1, e0, e1;
  int          d[3];
  int          k, ndone;

  initial begin
    reset = 1'b1; enable = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; zeta = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_r0", 32'(r0), 32'd0);
    chk("rst_r1", 32'(r1), 32'd0);
    reset = 1'b0;

    run_op(16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 1'b0, 1'b1, g0, g1);
    chk("ones_r0", 32'(g0), 32'h00A9);
    chk("ones_r1", 32'(g1), 32'h0152);

    run_op(16'hFFFF, 16'd0, 16'd1, 16'd0, 16'd0, 1'b0, 1'b1, g0, g1);
    chk("neg_r0", 32'(g0), 32'hFF57);
    chk("neg_r1", 32'(g1), 32'h0000);

    run_op(16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 1'b1, 1'b1, g0, g1);
    chk("toggle_r0", 32'(g0), 32'h0000);
    chk("toggle_r1", 32'(g1), 32'h00A9);
    chk("hold_r1", 32'(r1), 32'h00A9);

    // enable held high: three back-to-back operations
    @(negedge clk);
    a0 = 16'd3; a1 = 16'd5; b0 = 16'd7; b1 = 16'hFFFE; zeta = 16'd2285;
    enable = 1'b1;
    k = 0;
    for (int i = 0; i < 80 && k < 3; i++) begin
      @(negedge clk);
      if (done) begin
        d[k] = cyc;
        k++;
        if (k == 3) enable = 1'b0;
      end
    end
    enable = 1'b0;
    chk("b2b_count", 32'(k), 32'd3);
    if (k == 3) begin
      chk("b2b_gap1", 32'(d[1] - d[0]), 32'd17);
      chk("b2b_gap2", 32'(d[2] - d[1]), 32'd17);
      chk("b2b_r0", 32'(r0), 32'(r0_ref(16'd3, 16'd5, 16'd7, 16'hFFFE, 16'd2285)));
      chk("b2b_r1", 32'(r1), 32'(r1_ref(16'd3, 16'd5, 16'd7, 16'hFFFE, 16'd2285)));
    end
    @(negedge clk);
    chk("b2b_done_width", 32'(done), 32'd0);
    repeat (20) @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);

    // reset in cycle 8 of an operation
    @(negedge clk);
    a0 = 16'd100; a1 = 16'd200; b0 = 16'd300; b1 = 16'd400; zeta = 16'd17;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_r0", 32'(r0), 32'd0);
    chk("abort_r1", 32'(r1), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(16'd100, 16'd200, 16'd300, 16'd400, 16'd17, 1'b0, 1'b1, g0, g1);
    chk("post_abort_r0", 32'(g0), 32'(r0_ref(16'd100, 16'd200, 16'd300, 16'd400, 16'd17)));
    chk("post_abort_r1", 32'(g1), 32'(r1_ref(16'd100, 16'd200, 16'd300, 16'd400, 16'd17)));

    // reset and enable in the same cycle: reset wins
    @(negedge clk);
    reset = 1'b1; enable = 1'b1;
    @(negedge clk);
    reset = 1'b0; enable = 1'b0;
    chk("rst_prio_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rst_prio_idle", 32'(busy), 32'd0);

    // random signed operands
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] ra0, ra1, rb0, rb1, rz;
      ra0 = 16'($urandom); ra1 = 16'($urandom); rb0 = 16'($urandom);
      rb1 = 16'($urandom); rz = 16'($urandom);
      e0 = r0_ref(ra0, ra1, rb0, rb1, rz);
      e1 = r1_ref(ra0, ra1, rb0, rb1, rz);
      run_op(ra0, ra1, rb0, rb1, rz, n[0], 1'b0, g0, g1);
      chk("rand_r0", 32'(g0), 32'(e0));
      chk("rand_r1", 32'(g1), 32'(e1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
